// File: rtl/sdram_pll_rst_pkg.sv
// Shared state codes and default timing for the SDRAM PLL reset/lock sequencer.
// The bench uses the same state names to describe the expected sequence.
package sdram_pll_rst_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST    = 3'd0,
    ST_WAIT_LOCK  = 3'd1,
    ST_STABLE     = 3'd2,
    ST_SDRAM_INIT = 3'd3,
    ST_RUN        = 3'd4,
    ST_RETRY      = 3'd5,
    ST_FAULT      = 3'd6
  } state_t;

  localparam int DEF_SYNC_STAGES        = 2;
  localparam int DEF_PLL_RST_CYCLES     = 8;
  localparam int DEF_LOCK_TIMEOUT       = 27000;
  localparam int DEF_LOCK_STABLE_CYCLES = 256;
  localparam int DEF_INIT_TIMEOUT       = 8192;
  localparam int DEF_MAX_RETRIES        = 3;

  localparam logic [3:0] RETRY_SAT = 4'hF;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sdram_pll_reset_seq_bit_sync.sv
// Multi-flop level synchronizer for an asynchronous single-bit input.
// All stages clear to 0 on srst so a stale input cannot leak through reset.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic srst,
  input  logic d,
  output logic q
);

  logic [STAGES:0] chain;

  assign chain[0] = d;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      logic stage_reg;
      always_ff @(posedge clk) begin
        if (srst) stage_reg <= 1'b0;
        else      stage_reg <= chain[gi];
      end
      assign chain[gi+1] = stage_reg;
    end
  endgenerate

  assign q = chain[STAGES];

endmodule

// File: rtl/sdram_pll_reset_seq.sv
// Reset/lock sequencer on the free-running reference clock: pulses the PLL reset,
// waits for stable lock, releases SDRAM then system reset, retries and faults on failure.
module sdram_pll_reset_seq
  import sdram_pll_rst_pkg::*;
#(
  parameter int SYNC_STAGES        = DEF_SYNC_STAGES,
  parameter int PLL_RST_CYCLES     = DEF_PLL_RST_CYCLES,
  parameter int LOCK_TIMEOUT       = DEF_LOCK_TIMEOUT,
  parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int INIT_TIMEOUT       = DEF_INIT_TIMEOUT,
  parameter int MAX_RETRIES        = DEF_MAX_RETRIES
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       sdram_init_done,
  output logic       pll_rst,
  output logic       sdram_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fault,
  output logic [3:0] retry_cnt
);

  localparam int CNT_MAX = max_int(LOCK_TIMEOUT, INIT_TIMEOUT);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] INIT_LAST    = CNT_W'(INIT_TIMEOUT - 1);
  localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

  logic locked_s;
  logic done_s;

  bit_sync #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk  (refclk),
    .srst (rst),
    .d    (pll_locked),
    .q    (locked_s)
  );

  bit_sync #(.STAGES(SYNC_STAGES)) u_done_sync (
    .clk  (refclk),
    .srst (rst),
    .d    (sdram_init_done),
    .q    (done_s)
  );

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [3:0]       retry_cnt_reg, retry_cnt_next;
  logic             pll_rst_reg, pll_rst_next;
  logic             sdram_rst_reg, sdram_rst_next;
  logic             sys_rst_reg, sys_rst_next;
  logic             ready_reg, ready_next;
  logic             fault_reg, fault_next;

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg + CNT_W'(1);
    retry_cnt_next = retry_cnt_reg;

    case (state_reg)
      ST_PLL_RST: begin
        if (cnt_reg == PLL_RST_LAST) state_next = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (locked_s)                state_next = ST_STABLE;
        else if (cnt_reg == LOCK_LAST) state_next = ST_RETRY;
      end
      ST_STABLE: begin
        // A lost lock just restarts the stability window; it is not a retry.
        if (!locked_s)                   state_next = ST_WAIT_LOCK;
        else if (cnt_reg == STABLE_LAST) state_next = ST_SDRAM_INIT;
      end
      ST_SDRAM_INIT: begin
        if (!locked_s)                 state_next = ST_RETRY;
        else if (done_s)               state_next = ST_RUN;
        else if (cnt_reg == INIT_LAST) state_next = ST_RETRY;
      end
      ST_RUN: begin
        if (!locked_s) state_next = ST_RETRY;
      end
      ST_RETRY: begin
        retry_cnt_next = (retry_cnt_reg == RETRY_SAT) ? RETRY_SAT : retry_cnt_reg + 4'd1;
        state_next     = (retry_cnt_next >= RETRY_LIMIT) ? ST_FAULT : ST_PLL_RST;
      end
      ST_FAULT: begin
        state_next = ST_FAULT;
      end
      default: begin
        state_next = ST_PLL_RST;
      end
    endcase

    // Untimed states park the counter so it can never wrap.
    if ((state_next != state_reg) || (state_next inside {ST_RUN, ST_RETRY, ST_FAULT}))
      cnt_next = '0;

    pll_rst_next   = state_next inside {ST_PLL_RST, ST_RETRY, ST_FAULT};
    sdram_rst_next = !(state_next inside {ST_SDRAM_INIT, ST_RUN});
    sys_rst_next   = (state_next != ST_RUN);
    ready_next     = (state_next == ST_RUN);
    fault_next     = (state_next == ST_FAULT);
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_reg     <= ST_PLL_RST;
      cnt_reg       <= '0;
      retry_cnt_reg <= 4'd0;
      pll_rst_reg   <= 1'b1;
      sdram_rst_reg <= 1'b1;
      sys_rst_reg   <= 1'b1;
      ready_reg     <= 1'b0;
      fault_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      retry_cnt_reg <= retry_cnt_next;
      pll_rst_reg   <= pll_rst_next;
      sdram_rst_reg <= sdram_rst_next;
      sys_rst_reg   <= sys_rst_next;
      ready_reg     <= ready_next;
      fault_reg     <= fault_next;
    end
  end

  assign pll_rst   = pll_rst_reg;
  assign sdram_rst = sdram_rst_reg;
  assign sys_rst   = sys_rst_reg;
  assign ready     = ready_reg;
  assign fault     = fault_reg;
  assign retry_cnt = retry_cnt_reg;

endmodule

// File: tb/tb_sdram_pll_reset_seq.sv
// Randomized bench for sdram_pll_reset_seq against a queue-delayed phase/age reference model.
// Directed scenarios add latency checks on output edges measured in clock ticks.
module tb_sdram_pll_reset_seq;
  import sdram_pll_rst_pkg::*;

  localparam int P_SYNC = 2;
  localparam int P_PRC  = 4;
  localparam int P_LT   = 64;
  localparam int P_LSC  = 16;
  localparam int P_IT   = 128;
  localparam int P_MR   = 3;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       sdram_init_done = 1'b0;
  logic       pll_rst, sdram_rst, sys_rst, ready, fault;
  logic [3:0] retry_cnt;

  sdram_pll_reset_seq #(
    .SYNC_STAGES        (P_SYNC),
    .PLL_RST_CYCLES     (P_PRC),
    .LOCK_TIMEOUT       (P_LT),
    .LOCK_STABLE_CYCLES (P_LSC),
    .INIT_TIMEOUT       (P_IT),
    .MAX_RETRIES        (P_MR)
  ) dut (
    .refclk          (refclk),
    .rst             (rst),
    .pll_locked      (pll_locked),
    .sdram_init_done (sdram_init_done),
    .pll_rst         (pll_rst),
    .sdram_rst       (sdram_rst),
    .sys_rst         (sys_rst),
    .ready           (ready),
    .fault           (fault),
    .retry_cnt       (retry_cnt)
  );

  always #5 refclk = ~refclk;

  int total = 0;
  int bad   = 0;
  int tk    = 0;

  // reference model: phase, cycles spent in it, retries, input delay lines
  state_t m_phase = ST_PLL_RST;
  int     m_age   = 0;
  int     m_retry = 0;
  bit     lq[$];
  bit     dq[$];

  // stimulus knobs and bookkeeping
  int lock_delay, done_delay, glitch_at, drop_at, drop_len;
  bit stale_done, dropped;
  int since_pll, since_sdram, since_ready, drop_left;

  int lock_rise_tk, lock_fall_tk, done_rise_tk, rel_tk;
  int pll_fall_tk, prev_pll_fall_tk, pll_rise_tk, sdram_fall_tk;
  int sys_fall_tk, ready_rise_tk, ready_fall_tk;
  logic [8:0] prev_obs = '0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s @tick %0d: got=%0h want=%0h", tag, tk, got, want);
    end
  endtask

  function automatic logic [8:0] model_outs();
    logic mp, ms, ys, rd, ft;
    mp = m_phase inside {ST_PLL_RST, ST_RETRY, ST_FAULT};
    ms = !(m_phase inside {ST_SDRAM_INIT, ST_RUN});
    ys = (m_phase != ST_RUN);
    rd = (m_phase == ST_RUN);
    ft = (m_phase == ST_FAULT);
    return {mp, ms, ys, rd, ft, 4'(m_retry)};
  endfunction

  task automatic model_step();
    bit     ls, ds;
    state_t nxt;
    if (rst) begin
      m_phase = ST_PLL_RST;
      m_age   = 0;
      m_retry = 0;
      lq = {};
      dq = {};
      for (int i = 0; i < P_SYNC; i++) begin
        lq.push_back(1'b0);
        dq.push_back(1'b0);
      end
      return;
    end
    ls = lq.pop_front();
    ds = dq.pop_front();
    lq.push_back(pll_locked);
    dq.push_back(sdram_init_done);
    nxt = m_phase;
    case (m_phase)
      ST_PLL_RST:    if (m_age == P_PRC - 1) nxt = ST_WAIT_LOCK;
      ST_WAIT_LOCK:  if (ls) nxt = ST_STABLE; else if (m_age == P_LT - 1) nxt = ST_RETRY;
      ST_STABLE:     if (!ls) nxt = ST_WAIT_LOCK; else if (m_age == P_LSC - 1) nxt = ST_SDRAM_INIT;
      ST_SDRAM_INIT: if (!ls) nxt = ST_RETRY; else if (ds) nxt = ST_RUN;
                     else if (m_age == P_IT - 1) nxt = ST_RETRY;
      ST_RUN:        if (!ls) nxt = ST_RETRY;
      ST_RETRY: begin
        m_retry = (m_retry < 15) ? m_retry + 1 : 15;
        nxt = (m_retry >= P_MR) ? ST_FAULT : ST_PLL_RST;
      end
      default: nxt = m_phase;
    endcase
    m_age   = (nxt != m_phase) ? 0 : m_age + 1;
    m_phase = nxt;
  endtask

  task automatic apply_stim();
    logic [8:0] o;
    logic nl, nd;
    o = model_outs();
    since_pll   = o[8] ? 0 : since_pll + 1;
    since_sdram = o[7] ? 0 : since_sdram + 1;
    since_ready = o[5] ? since_ready + 1 : 0;
    nl = (lock_delay >= 0) && !o[8] && (since_pll >= lock_delay);
    if (glitch_at >= 0 && lock_delay >= 0 && since_pll == lock_delay + glitch_at) nl = 1'b0;
    if (drop_at >= 0 && !dropped && o[5] && since_ready == drop_at) begin
      dropped   = 1'b1;
      drop_left = drop_len;
    end
    if (drop_left > 0) begin
      nl = 1'b0;
      drop_left--;
    end
    nd = stale_done || (done_delay >= 0 && !o[7] && since_sdram >= done_delay);
    if (nl && !pll_locked) lock_rise_tk = tk;
    if (!nl && pll_locked && o[5]) lock_fall_tk = tk;
    if (nd && !sdram_init_done) done_rise_tk = tk;
    pll_locked      = nl;
    sdram_init_done = nd;
  endtask

  task automatic observe();
    logic [8:0] obs;
    obs = {pll_rst, sdram_rst, sys_rst, ready, fault, retry_cnt};
    check_val("outs", 32'(obs), 32'(model_outs()));
    if (prev_obs[8] && !obs[8]) begin
      prev_pll_fall_tk = pll_fall_tk;
      pll_fall_tk      = tk;
    end
    if (!prev_obs[8] && obs[8]) pll_rise_tk   = tk;
    if (prev_obs[7] && !obs[7]) sdram_fall_tk = tk;
    if (prev_obs[6] && !obs[6]) sys_fall_tk   = tk;
    if (!prev_obs[5] && obs[5]) ready_rise_tk = tk;
    if (prev_obs[5] && !obs[5]) ready_fall_tk = tk;
    prev_obs = obs;
  endtask

  task automatic tick();
    @(posedge refclk);
    tk++;
    model_step();
    #1;
    apply_stim();
    @(negedge refclk);
    observe();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic start_scenario(input int ld, input int dd, input int ga,
                                input int da, input int dl, input bit sd);
    lock_delay = ld; done_delay = dd; glitch_at = ga;
    drop_at = da; drop_len = dl; stale_done = sd;
    dropped = 1'b0; drop_left = 0;
    since_pll = 0; since_sdram = 0; since_ready = 0;
    lock_rise_tk = -1000; lock_fall_tk = -1000; done_rise_tk = -1000;
    pll_fall_tk = -1000; prev_pll_fall_tk = -1000; pll_rise_tk = -1000;
    sdram_fall_tk = -1000; sys_fall_tk = -1000;
    ready_rise_tk = -1000; ready_fall_tk = -1000;
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    rel_tk = tk;
  endtask

  initial begin
    // nominal bring-up
    start_scenario(10, 20, -1, -1, 0, 1'b0);
    run(80);
    check_val("pll_rst_width", 32'(pll_fall_tk - rel_tk), 32'(P_PRC));
    check_val("sdram_rel_lat", 32'(sdram_fall_tk - lock_rise_tk), 32'(P_SYNC + P_LSC + 1));
    check_val("sys_rel_lat", 32'(sys_fall_tk - done_rise_tk), 32'(P_SYNC + 1));
    check_val("ready_lat", 32'(ready_rise_tk - done_rise_tk), 32'(P_SYNC + 1));
    check_val("nominal_retry", 32'(retry_cnt), 32'd0);

    // one-cycle lock glitch in the middle of the stability window
    start_scenario(5, 20, 11, -1, 0, 1'b0);
    run(100);
    check_val("glitch_restart", 32'(sdram_fall_tk - lock_rise_tk), 32'(P_SYNC + P_LSC + 1));
    check_val("glitch_retry", 32'(retry_cnt), 32'd0);
    check_val("glitch_ready", 32'(ready), 32'd1);

    // lock never arrives: three timeouts then fault
    start_scenario(-1, -1, -1, -1, 0, 1'b0);
    run(300);
    check_val("retry_period", 32'(pll_fall_tk - prev_pll_fall_tk), 32'(P_PRC + P_LT + 1));
    check_val("fault_flag", 32'(fault), 32'd1);
    check_val("fault_retry", 32'(retry_cnt), 32'(P_MR));
    check_val("fault_resets", 32'({pll_rst, sdram_rst, sys_rst}), 32'h7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("rst_in_fault", 32'({pll_rst, sdram_rst, sys_rst, ready, fault, retry_cnt}), 32'h1C0);

    // lock loss while running, then relock
    start_scenario(8, 15, -1, $urandom_range(2, 20), $urandom_range(1, 4), 1'b0);
    run(200);
    check_val("loss_ready_lat", 32'(ready_fall_tk - lock_fall_tk), 32'(P_SYNC + 1));
    check_val("loss_pll_lat", 32'(pll_rise_tk - lock_fall_tk), 32'(P_SYNC + 1));
    check_val("loss_retry", 32'(retry_cnt), 32'd1);
    check_val("relock_ready", 32'(ready), 32'd1);

    // init never completes
    start_scenario(6, -1, -1, -1, 0, 1'b0);
    run(170);
    check_val("init_timeout", 32'(pll_rise_tk - sdram_fall_tk), 32'(P_IT));
    check_val("init_retry", 32'(retry_cnt), 32'd1);

    // done stuck high from an earlier run
    start_scenario(7, -1, -1, -1, 0, 1'b1);
    run(60);
    check_val("stale_sdram_lat", 32'(sdram_fall_tk - lock_rise_tk), 32'(P_SYNC + P_LSC + 1));
    check_val("stale_ready_lat", 32'(ready_rise_tk - sdram_fall_tk), 32'd1);

    // reset while waiting for SDRAM init
    start_scenario(6, -1, -1, -1, 0, 1'b0);
    run(40);
    check_val("in_init", 32'({sdram_rst, sys_rst}), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("rst_in_init", 32'({pll_rst, sdram_rst, sys_rst, ready, fault, retry_cnt}), 32'h1C0);

    // randomized sequences with occasional mid-run resets
    for (int it = 0; it < 20; it++) begin
      start_scenario(($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(1, 30)),
                     ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(1, 40)),
                     ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 30)),
                     ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(1, 30)),
                     $urandom_range(1, 5), 1'($urandom_range(0, 5) == 0));
      for (int c = 0; c < 400; c++) begin
        if ($urandom_range(0, 299) == 0) rst = 1'b1;
        tick();
        rst = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
